shk_uart_fifo_bridge: RTL and testbench

//  Buffered full-duplex UART bridge between shake valid/ready byte streams and a UART pin pair.

---
 rtl/shk_uart_pkg.sv | 26 ++
 rtl/shk_uart_sfifo.sv | 63 ++++++
 rtl/shk_uart_fifo_bridge.sv | 260 ++++++++++++++++++++++++++
 tb/tb_shk_uart_fifo_bridge.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/shk_uart_pkg.sv
// Shared types and helpers for the buffered shake UART bridge.
// Optional parity support is selected with the SHK_UART_PARITY_EN macro in the top.
package shk_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_st_e;

  localparam int ERR_FRAME  = 0;
  localparam int ERR_OVF    = 1;
  localparam int ERR_PAR    = 2;
  localparam int ERR_FSTART = 3;

  // Bits needed to hold values 0..v-1 (at least 1).
  function automatic int LOG2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/shk_uart_sfifo.sv
// Synchronous first-word-fall-through FIFO with a registered head word.
// Push is refused when full even if a pop happens in the same cycle.
module shk_uart_sfifo
  import shk_uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = LOG2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_nxt;
  logic [AW:0]      cnt_q;
  logic [WIDTH-1:0] head_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = head_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rd_nxt  = rd_ptr_q + 1'b1;

  // Storage array; no reset needed, the head register masks it.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers wrap naturally (power-of-two depth); head register tracks the oldest word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_nxt;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      // Incoming word becomes head when the FIFO is (or is about to be) empty.
      if (do_push && (empty_o || (do_pop && cnt_q == (AW+1)'(1))))
        head_q <= wdata_i;
      else if (do_pop && cnt_q > (AW+1)'(1))
        head_q <= mem_q[rd_nxt];
    end
  end

endmodule

// File: rtl/shk_uart_fifo_bridge.sv
// Buffered full-duplex UART bridge between shake valid/ready streams and a UART pin pair.
// Define SHK_UART_PARITY_EN to add a parity bit (sense set by MD_PARITY_ODD) on TX and RX.
module shk_uart_fifo_bridge
  import shk_uart_pkg::*;
#(
  parameter int NB_SYS_FRE    = 100_000_000,
  parameter int NB_BAUD_RATE  = 115200,
  parameter int WD_SHK_DATA   = 8,
  parameter int NB_STOP_BITS  = 1,
  parameter int NB_FIFO_DEPTH = 16,
  parameter int MD_PARITY_ODD = 0,
  parameter int WD_ERR_INFO   = 4
) (
  input  logic                   i_sys_clk,
  input  logic                   i_sys_resetn,
  input  logic                   s_shk_wr_valid,
  input  logic [WD_SHK_DATA-1:0] s_shk_wr_mdata,
  output logic                   s_shk_wr_ready,
  output logic                   m_shk_rd_valid,
  output logic [WD_SHK_DATA-1:0] m_shk_rd_mdata,
  input  logic                   m_shk_rd_ready,
  input  logic                   s_port_uart_mtx,
  output logic                   s_port_uart_mrx,
  input  logic                   i_err_clr,
  output logic [WD_ERR_INFO-1:0] m_err_uart_info1
);

  localparam int NB_BAUD_NUMB = NB_SYS_FRE / NB_BAUD_RATE;
  localparam int WB = LOG2(NB_BAUD_NUMB);
  localparam int WN = LOG2(WD_SHK_DATA + 1);
  localparam int AW = LOG2(NB_FIFO_DEPTH);
  localparam logic [WB-1:0] BAUD_LAST = WB'(NB_BAUD_NUMB - 1);
  localparam logic [WB-1:0] BAUD_MID  = WB'(NB_BAUD_NUMB / 2 - 1);
  localparam logic [WN-1:0] DATA_LAST = WN'(WD_SHK_DATA - 1);
  localparam logic [WN-1:0] STOP_LAST = WN'(NB_STOP_BITS - 1);

  // ---------------- FIFOs ----------------
  logic                   tx_full, tx_empty, tx_pop;
  logic [WD_SHK_DATA-1:0] tx_dout;
  logic [AW:0]            tx_cnt_w, rx_cnt_w;
  logic                   rx_full, rx_empty, rx_push;
  logic [WD_SHK_DATA-1:0] rx_sh_q;
  logic                   unused_cfg;

  shk_uart_sfifo #(.WIDTH(WD_SHK_DATA), .DEPTH(NB_FIFO_DEPTH)) u_tx_fifo (
    .clk_i(i_sys_clk), .rst_ni(i_sys_resetn),
    .push_i(s_shk_wr_valid), .wdata_i(s_shk_wr_mdata), .pop_i(tx_pop),
    .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_cnt_w), .rdata_o(tx_dout)
  );

  shk_uart_sfifo #(.WIDTH(WD_SHK_DATA), .DEPTH(NB_FIFO_DEPTH)) u_rx_fifo (
    .clk_i(i_sys_clk), .rst_ni(i_sys_resetn),
    .push_i(rx_push), .wdata_i(rx_sh_q), .pop_i(m_shk_rd_ready),
    .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_cnt_w), .rdata_o(m_shk_rd_mdata)
  );

  assign s_shk_wr_ready = !tx_full;
  assign m_shk_rd_valid = !rx_empty;
  assign unused_cfg     = ^{tx_cnt_w, rx_cnt_w, 1'(MD_PARITY_ODD)};

`ifdef SHK_UART_PARITY_EN
  localparam logic PAR_ODD = 1'(MD_PARITY_ODD);
`endif

  // ---------------- TX ----------------
  uart_st_e               tx_st_q;
  logic [WB-1:0]          tx_cnt_q;
  logic [WN-1:0]          tx_bit_q;
  logic [WD_SHK_DATA-1:0] tx_sh_q;
  logic                   tx_par_q;
  logic                   mrx_q, tx_line, tx_end;

  assign tx_end = (tx_cnt_q == BAUD_LAST);
  // Pop when idle, or at the very end of the last stop bit for back-to-back frames.
  assign tx_pop = !tx_empty &&
                  (tx_st_q == ST_IDLE || (tx_st_q == ST_STOP && tx_end && tx_bit_q == STOP_LAST));
  assign s_port_uart_mrx = mrx_q;

  // Line level implied by the current TX state; registered one cycle later onto the pin.
  always_comb begin
    tx_line = 1'b1;
    case (tx_st_q)
      ST_START:  tx_line = 1'b0;
      ST_DATA:   tx_line = tx_sh_q[0];
      ST_PARITY: tx_line = tx_par_q;
      default:   tx_line = 1'b1;
    endcase
  end

  // TX FSM with baud and bit counters; pin driven from a register.
  always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
    if (!i_sys_resetn) begin
      tx_st_q  <= ST_IDLE;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q  <= '0;
      tx_par_q <= 1'b0;
      mrx_q    <= 1'b1;
    end else begin
      mrx_q <= tx_line;
      if (tx_pop) begin
        tx_st_q  <= ST_START;
        tx_cnt_q <= '0;
        tx_bit_q <= '0;
        tx_sh_q  <= tx_dout;
`ifdef SHK_UART_PARITY_EN
        tx_par_q <= (^tx_dout) ^ PAR_ODD;
`else
        tx_par_q <= 1'b0;
`endif
      end else begin
        tx_cnt_q <= tx_end ? '0 : tx_cnt_q + 1'b1;
        case (tx_st_q)
          ST_START: if (tx_end) tx_st_q <= ST_DATA;
          ST_DATA: if (tx_end) begin
            tx_sh_q <= {1'b0, tx_sh_q[WD_SHK_DATA-1:1]};
            if (tx_bit_q == DATA_LAST) begin
              tx_bit_q <= '0;
`ifdef SHK_UART_PARITY_EN
              tx_st_q  <= ST_PARITY;
`else
              tx_st_q  <= ST_STOP;
`endif
            end else begin
              tx_bit_q <= tx_bit_q + 1'b1;
            end
          end
          ST_PARITY: if (tx_end) tx_st_q <= ST_STOP;
          ST_STOP: if (tx_end) begin
            if (tx_bit_q == STOP_LAST) tx_st_q <= ST_IDLE;
            else                       tx_bit_q <= tx_bit_q + 1'b1;
          end
          default: tx_cnt_q <= '0;
        endcase
      end
    end
  end

  // ---------------- RX ----------------
  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  uart_st_e      rx_st_q;
  logic [WB-1:0] rx_cnt_q;
  logic [WN-1:0] rx_bit_q;
  logic          rx_perr, rx_end, rx_stop_smp;
  logic          set_frame, set_ovf, set_par, set_fstart;

  assign rx_end      = (rx_cnt_q == BAUD_LAST);
  assign rx_stop_smp = (rx_st_q == ST_STOP) && rx_end;
  assign rx_push     = rx_stop_smp && rx_s2_q && !rx_perr;
  assign set_frame   = rx_stop_smp && !rx_s2_q;
  assign set_par     = rx_stop_smp && rx_s2_q && rx_perr;
  assign set_ovf     = rx_push && rx_full;
  assign set_fstart  = (rx_st_q == ST_START) && (rx_cnt_q == BAUD_MID) && rx_s2_q;

  // Two-flop synchroniser plus a delayed copy for falling-edge detection.
  always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
    if (!i_sys_resetn) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= s_port_uart_mtx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

`ifdef SHK_UART_PARITY_EN
  logic rx_perr_q;
  assign rx_perr = rx_perr_q;
`else
  assign rx_perr = 1'b0;
`endif

  // RX FSM: only a falling edge re-arms, so a line held low after a bad stop is ignored.
  always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
    if (!i_sys_resetn) begin
      rx_st_q  <= ST_IDLE;
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q  <= '0;
`ifdef SHK_UART_PARITY_EN
      rx_perr_q <= 1'b0;
`endif
    end else begin
      case (rx_st_q)
        ST_IDLE: begin
          rx_cnt_q <= '0;
          rx_bit_q <= '0;
          if (rx_prev_q && !rx_s2_q) begin
            rx_st_q <= ST_START;
`ifdef SHK_UART_PARITY_EN
            rx_perr_q <= 1'b0;
`endif
          end
        end
        ST_START: begin
          if (rx_cnt_q == BAUD_MID) begin
            rx_cnt_q <= '0;
            rx_st_q  <= rx_s2_q ? ST_IDLE : ST_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          rx_cnt_q <= rx_end ? '0 : rx_cnt_q + 1'b1;
          if (rx_end) begin
            rx_sh_q <= {rx_s2_q, rx_sh_q[WD_SHK_DATA-1:1]};
            if (rx_bit_q == DATA_LAST) begin
              rx_bit_q <= '0;
`ifdef SHK_UART_PARITY_EN
              rx_st_q  <= ST_PARITY;
`else
              rx_st_q  <= ST_STOP;
`endif
            end else begin
              rx_bit_q <= rx_bit_q + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          rx_cnt_q <= rx_end ? '0 : rx_cnt_q + 1'b1;
          if (rx_end) begin
            rx_st_q <= ST_STOP;
`ifdef SHK_UART_PARITY_EN
            rx_perr_q <= rx_s2_q ^ (^rx_sh_q) ^ PAR_ODD;
`endif
          end
        end
        ST_STOP: begin
          rx_cnt_q <= rx_end ? '0 : rx_cnt_q + 1'b1;
          if (rx_end) rx_st_q <= ST_IDLE;
        end
        default: rx_st_q <= ST_IDLE;
      endcase
    end
  end

  // ---------------- Errors ----------------
  logic [WD_ERR_INFO-1:0] err_q, err_d;

  // Sticky error bits; a set in the same cycle as a clear wins.
  always_comb begin
    err_d = err_q;
    if (i_err_clr) err_d = '0;
    if (set_frame)  err_d[ERR_FRAME]  = 1'b1;
    if (set_ovf)    err_d[ERR_OVF]    = 1'b1;
    if (set_par)    err_d[ERR_PAR]    = 1'b1;
    if (set_fstart) err_d[ERR_FSTART] = 1'b1;
  end

  // Error register.
  always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
    if (!i_sys_resetn) err_q <= '0;
    else               err_q <= err_d;
  end

  assign m_err_uart_info1 = err_q;

endmodule

// File: tb/tb_shk_uart_fifo_bridge.sv
// Self-checking bench for shk_uart_fifo_bridge at 16 clocks per bit.
module tb_shk_uart_fifo_bridge;

  localparam int NB    = 16;
  localparam int WD    = 8;
  localparam int STOPB = 1;
  localparam int PODD  = 1;
`ifdef SHK_UART_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FLEN = 1 + WD + PB + STOPB;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          wr_valid = 1'b0, wr_ready, rd_valid, rd_ready = 1'b0;
  logic [WD-1:0] wr_data = '0, rd_data;
  logic          mtx, mrx, err_clr = 1'b0, loop_en = 1'b0, tb_line = 1'b1;
  logic [3:0]    err;

  int checks = 0, errors = 0;

  assign mtx = loop_en ? mrx : tb_line;

  always #5 clk = ~clk;

  shk_uart_fifo_bridge #(
    .NB_SYS_FRE(100_000_000), .NB_BAUD_RATE(6_250_000), .WD_SHK_DATA(WD),
    .NB_STOP_BITS(STOPB), .NB_FIFO_DEPTH(16), .MD_PARITY_ODD(PODD), .WD_ERR_INFO(4)
  ) dut (
    .i_sys_clk(clk), .i_sys_resetn(rst_n),
    .s_shk_wr_valid(wr_valid), .s_shk_wr_mdata(wr_data), .s_shk_wr_ready(wr_ready),
    .m_shk_rd_valid(rd_valid), .m_shk_rd_mdata(rd_data), .m_shk_rd_ready(rd_ready),
    .s_port_uart_mtx(mtx), .s_port_uart_mrx(mrx),
    .i_err_clr(err_clr), .m_err_uart_info1(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Frame in time order: start, data LSB first, optional parity, stop bits.
  function automatic logic [FLEN-1:0] frame_of(input logic [WD-1:0] d);
    logic [FLEN-1:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int k = 0; k < WD; k++) f[1+k] = d[k];
`ifdef SHK_UART_PARITY_EN
    f[1+WD] = (PODD != 0) ? ~(^d) : (^d);
`endif
    return f;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bang(input logic [FLEN-1:0] f);
    for (int i = 0; i < FLEN; i++) begin
      tb_line = f[i];
      step(NB);
    end
    tb_line = 1'b1;
  endtask

  task automatic clear_err();
    err_clr = 1'b1; step(1); err_clr = 1'b0;
  endtask

  logic [WD-1:0]   exp_q[$];
  logic [WD-1:0]   got_q[$];
  logic [WD-1:0]   d;
  logic [FLEN-1:0] f;
  logic            acc;
  int              bad, cyc;

  initial begin
    // ---- reset ----
    step(3);
    chk("rst_mrx", mrx, 1);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    step(3);

    // ---- TX framing and latency ----
    for (int t = 0; t < 3; t++) begin
      d = (t == 0) ? 8'hA5 : (t == 1) ? 8'h01 : 8'($urandom_range(0, 255));
      f = frame_of(d);
      wr_data = d; wr_valid = 1'b1;
      @(posedge clk); #1;            // edge N: write accepted
      wr_valid = 1'b0;
      chk("tx_lat_n", mrx, 1);
      step(1);                        // edge N+1
      chk("tx_lat_n1", mrx, 1);
      step(1);                        // edge N+2: start bit begins
      for (int i = 0; i < FLEN; i++) begin
        bad = 0;
        for (int c = 0; c < NB; c++) begin
          if (mrx !== f[i]) bad++;
          step(1);
        end
        chk($sformatf("tx_bit%0d_b%0d", i, t), bad, 0);
      end
      chk("tx_idle_after", mrx, 1);
      step(5);
    end

    // ---- loopback burst ----
    loop_en = 1'b1; rd_ready = 1'b1;
    exp_q.delete(); got_q.delete();
    for (int k = 0; k < 17; k++) begin
      wr_data = (k < 16) ? 8'(k) : 8'($urandom_range(0, 255));
      wr_valid = 1'b1;
      acc = wr_ready;
      step(1);
      if (acc) exp_q.push_back(wr_data);
    end
    wr_valid = 1'b0;
    chk("burst_wr_ready_full", wr_ready, 0);
    chk("burst_accepted", exp_q.size(), 17);
    cyc = 0;
    while (got_q.size() < exp_q.size() && cyc < 17 * FLEN * NB + 500) begin
      @(negedge clk);
      if (rd_valid) got_q.push_back(rd_data);
      cyc++;
    end
    chk("loop_count", got_q.size(), exp_q.size());
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
      chk($sformatf("loop_byte%0d", k), got_q[k], exp_q[k]);
    chk("loop_err", err, 0);
    chk("loop_wr_ready", wr_ready, 1);
    step(2);
    loop_en = 1'b0; rd_ready = 1'b0;
    step(NB);

    // ---- false start ----
    tb_line = 1'b0; step(4); tb_line = 1'b1;
    step(40);
    chk("fstart_err", err, 4'b1000);
    chk("fstart_nopush", rd_valid, 0);
    clear_err();
    chk("fstart_clr", err, 0);

    // ---- framing error then good frame ----
    f = frame_of(8'h3C);
    f[1+WD+PB] = 1'b0;
    bang(f);
    step(20);
    chk("frame_err", err, 4'b0001);
    chk("frame_nopush", rd_valid, 0);
    clear_err();
    bang(frame_of(8'h55));
    step(10);
    chk("good_valid", rd_valid, 1);
    chk("good_data", rd_data, 8'h55);
    chk("good_err", err, 0);
    rd_ready = 1'b1; step(1); rd_ready = 1'b0;
    chk("good_drained", rd_valid, 0);

    // ---- RX overflow ----
    exp_q.delete();
    for (int k = 0; k < 17; k++) begin
      d = 8'($urandom_range(0, 255));
      if (k < 16) exp_q.push_back(d);
      bang(frame_of(d));
    end
    step(20);
    chk("ovf_err", err, 4'b0010);
    chk("ovf_valid", rd_valid, 1);
    chk("ovf_head", rd_data, exp_q[0]);
    step(7);
    chk("ovf_head_stable", rd_data, exp_q[0]);
    rd_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk($sformatf("ovf_byte%0d", k), rd_data, exp_q[k]);
      chk($sformatf("ovf_valid%0d", k), rd_valid, 1);
    end
    @(negedge clk);
    chk("ovf_empty", rd_valid, 0);
    @(posedge clk); #1;
    rd_ready = 1'b0;
    clear_err();

`ifdef SHK_UART_PARITY_EN
    // ---- parity error inbound ----
    d = 8'($urandom_range(0, 255));
    f = frame_of(d);
    f[1+WD] = ~f[1+WD];
    bang(f);
    step(20);
    chk("par_err", err, 4'b0100);
    chk("par_nopush", rd_valid, 0);
    clear_err();
`endif

    // ---- reset mid-frame ----
    wr_data = 8'h00; wr_valid = 1'b1; step(1); wr_valid = 1'b0;
    step(40);
    chk("mid_line_low", mrx, 0);
    rst_n = 1'b0; #1;
    chk("mid_rst_mrx", mrx, 1);
    chk("mid_rst_ready", wr_ready, 1);
    chk("mid_rst_err", err, 0);
    step(2);
    rst_n = 1'b1;
    step(3 * NB);
    chk("post_rst_idle", mrx, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
